// File: rtl/serial_magnitude_comparator_if.sv
// Operand/result bundle for the serial magnitude comparator.
// The master drives the request and operands; the slave (the comparator) returns status and result flags.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             greater;
    logic             lesser;
    logic             equal;

    modport master (
        output start, a_in, b_in,
        input  busy, done, greater, lesser, equal
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, greater, lesser, equal
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Serial unsigned magnitude comparator. Operands are compared MSB-first, one bit per clock,
// using the 1-bit comparator cell. The compare stops at the first differing bit.
//
// state | meaning
// IDLE  | waiting for start; result flags from the last compare are held
// SHIFT | comparing one operand bit per cycle, MSB first
// DONE  | one-cycle result pulse; a start here is accepted back-to-back

module comparator_1bit (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic lt,
    output logic eq
);
    assign gt = a & ~b;
    assign lt = ~a & b;
    assign eq = ~(a ^ b);
endmodule

module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_magnitude_comparator_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic             greater_q;
    logic             lesser_q;
    logic             equal_q;
    logic             cell_gt;
    logic             cell_lt;
    logic             cell_eq;
    logic             accept;
    logic             last_bit;
    logic             busy_c;
    logic             done_c;

    comparator_1bit u_cell (
        .a  (a_sh[WIDTH-1]),
        .b  (b_sh[WIDTH-1]),
        .gt (cell_gt),
        .lt (cell_lt),
        .eq (cell_eq)
    );

    // start is only honoured when no compare is in flight
    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign last_bit = cell_eq && (cnt == CW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (cell_gt || cell_lt || last_bit) state_nxt = DONE;
            DONE:    state_nxt = accept ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            SHIFT:   busy_c = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    // Operand shifters, bit counter and sticky result flags
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            greater_q <= 1'b0;
            lesser_q  <= 1'b0;
            equal_q   <= 1'b0;
        end else if (accept) begin
            a_sh      <= bus.a_in;
            b_sh      <= bus.b_in;
            cnt       <= CW'(WIDTH);
            greater_q <= 1'b0;
            lesser_q  <= 1'b0;
            equal_q   <= 1'b0;
        end else if (state == SHIFT) begin
            if (cell_gt) begin
                greater_q <= 1'b1;
            end else if (cell_lt) begin
                lesser_q <= 1'b1;
            end else if (last_bit) begin
                equal_q <= 1'b1;
            end else begin
                a_sh <= a_sh << 1;
                b_sh <= b_sh << 1;
                cnt  <= cnt - CW'(1);
            end
        end
    end

    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.greater = greater_q;
    assign bus.lesser  = lesser_q;
    assign bus.equal   = equal_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator (WIDTH=8 and WIDTH=1 builds).
// Outputs are observed as {busy, done, greater, lesser, equal}.
module tb_serial_magnitude_comparator;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator_if #(.WIDTH(8)) bus8 ();
    serial_magnitude_comparator_if #(.WIDTH(1)) bus1 ();

    serial_magnitude_comparator #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_magnitude_comparator #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    function automatic logic [4:0] obs8();
        return {bus8.busy, bus8.done, bus8.greater, bus8.lesser, bus8.equal};
    endfunction

    function automatic logic [4:0] obs1();
        return {bus1.busy, bus1.done, bus1.greater, bus1.lesser, bus1.equal};
    endfunction

    // number of equal leading bits from the MSB
    function automatic int lead_eq(logic [7:0] a, logic [7:0] b);
        for (int i = 7; i >= 0; i--)
            if (a[i] != b[i]) return 7 - i;
        return 8;
    endfunction

    function automatic logic [2:0] ref_flags(int unsigned a, int unsigned b);
        return {a > b, a < b, a == b};
    endfunction

    task automatic chk(string tag, logic [4:0] obs, logic [4:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one compare on the 8-bit DUT and check every cycle to the result, then hold cycles
    task automatic run8(logic [7:0] a, logic [7:0] b, int hold);
        int         k;
        int         lat;
        logic [2:0] f;
        bus8.a_in  = a;
        bus8.b_in  = b;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.a_in  = 8'($urandom);
        bus8.b_in  = 8'($urandom);
        k   = lead_eq(a, b);
        lat = (k == 8) ? 9 : k + 2;
        f   = ref_flags(32'(a), 32'(b));
        for (int c = 1; c <= lat; c++) begin
            chk($sformatf("cmp a=%02h b=%02h cyc=%0d", a, b, c), obs8(),
                (c < lat) ? 5'b10000 : {2'b01, f});
            if (c < lat) tick();
        end
        for (int h = 1; h <= hold; h++) begin
            tick();
            chk($sformatf("hold a=%02h b=%02h h=%0d", a, b, h), obs8(), {2'b00, f});
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       a1;
        logic       b1;

        rst        = 1'b1;
        bus8.start = 1'b0;
        bus8.a_in  = '0;
        bus8.b_in  = '0;
        bus1.start = 1'b0;
        bus1.a_in  = '0;
        bus1.b_in  = '0;
        tick();
        tick();
        chk("reset w8", obs8(), 5'b00000);
        chk("reset w1", obs1(), 5'b00000);
        rst = 1'b0;
        tick();

        run8(8'hA5, 8'hA5, 1);
        run8(8'h80, 8'h7F, 1);
        run8(8'h12, 8'h13, 5);

        // start ignored mid-SHIFT, accepted in DONE
        bus8.a_in = 8'h40; bus8.b_in = 8'h00; bus8.start = 1'b1;
        tick();
        chk("b2b T+1", obs8(), 5'b10000);
        bus8.a_in = 8'hFF; bus8.b_in = 8'h01;
        tick();
        bus8.start = 1'b0;
        chk("b2b T+2", obs8(), 5'b10000);
        tick();
        chk("b2b T+3 greater", obs8(), 5'b01100);
        bus8.a_in = 8'h01; bus8.b_in = 8'h02; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        chk("b2b T+4 cleared", obs8(), 5'b10000);
        for (int c = 5; c <= 10; c++) begin
            tick();
            chk($sformatf("b2b T+%0d", c), obs8(), 5'b10000);
        end
        tick();
        chk("b2b T+11 lesser", obs8(), 5'b01010);
        tick();
        chk("b2b hold", obs8(), 5'b00010);

        // reset aborts an in-flight compare
        bus8.a_in = 8'h33; bus8.b_in = 8'h33; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        chk("abort T+1", obs8(), 5'b10000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort T+4", obs8(), 5'b00000);
        tick();
        chk("abort T+5", obs8(), 5'b00000);
        run8(8'h5C, 8'h5A, 2);

        // randomized compares, biased toward long shared prefixes
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 8'($urandom);
                1:       rb = ra;
                2:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
                default: rb = ra ^ 8'($urandom_range(1, 7));
            endcase
            run8(ra, rb, int'($urandom_range(0, 2)));
        end

        // WIDTH=1 build: every operand pair
        for (int p = 0; p < 4; p++) begin
            a1 = (p >= 2);
            b1 = (p % 2 == 1);
            bus1.a_in  = a1;
            bus1.b_in  = b1;
            bus1.start = 1'b1;
            tick();
            bus1.start = 1'b0;
            chk($sformatf("w1 a=%0d b=%0d busy", a1, b1), obs1(), 5'b10000);
            tick();
            chk($sformatf("w1 a=%0d b=%0d done", a1, b1), obs1(),
                {2'b01, ref_flags(32'(a1), 32'(b1))});
            tick();
            chk($sformatf("w1 a=%0d b=%0d hold", a1, b1), obs1(),
                {2'b00, ref_flags(32'(a1), 32'(b1))});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Multi-cycle N-bit magnitude comparator built on the team's 1-bit comparator cell (comparator_1bit). It latches two WIDTH-bit operands on a start request and steps the 1-bit cell MSB-first, one bit per clock. It stops at the first differing bit and reports greater/lesser/equal with a one-cycle done pulse. It sits directly downstream of the operand registers and upstream of any consumer that needs a word-level compare result.

## Interface
- WIDTH, 8, operand width in bits; legal range 1..32.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only when the block can accept (IDLE or DONE).
- a_in  input  WIDTH  operand A; captured in the accepting cycle.
- b_in  input  WIDTH  operand B; captured in the accepting cycle.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when a result is valid.
- greater  output  1  A > B; valid from done until the next accepted start.
- lesser  output  1  A < B; same validity as greater.
- equal  output  1  A == B; same validity as greater.

## Operation
- Internal state: a_sh and b_sh shift registers (WIDTH bits each), bit counter cnt of $clog2(WIDTH)+1 bits, and a 3-state FSM (IDLE, SHIFT, DONE).
- The 1-bit cell is fed a_sh[WIDTH-1] and b_sh[WIDTH-1]. Its three outputs are consumed combinationally within the same cycle.
- IDLE:
  - If start=1: load a_sh<=a_in, b_sh<=b_in, cnt<=WIDTH, clear greater/lesser/equal to 0, go to SHIFT.
  - Otherwise hold all state and outputs.
- SHIFT, each cycle:
  - If the cell reports greater or lesser: register that flag (equal stays 0) and go to DONE.
  - Else if cnt==1: register equal=1 and go to DONE.
  - Else: shift a_sh and b_sh left by 1, decrement cnt, stay in SHIFT.
- DONE lasts one cycle, with done=1.
  - If start=1: accept it exactly as in IDLE, going directly to SHIFT (back-to-back compares).
  - Otherwise go to IDLE.
- start is ignored in SHIFT. Operands must not be re-sampled mid-compare.
- Result flags are mutually exclusive. All three are 0 between acceptance and the result.
- Unsigned compare only.

## Timing
- Reset values (at any rst=1 edge):
  - State: FSM=IDLE, cnt=0, a_sh=0, b_sh=0.
  - Outputs: busy=0, done=0, greater=0, lesser=0, equal=0.
- Reset mid-SHIFT or in DONE aborts the compare: no done pulse, flags cleared. rst has priority over start in the same cycle.
- Start accepted at edge T (start=1 in IDLE/DONE). busy=1 from cycle T+1.
- Let k be the number of leading bits, counted from the MSB, that are equal (0..WIDTH).
  - Differing: SHIFT occupies cycles T+1..T+k+1. done=1 with a valid flag in cycle T+k+2. Latency is k+2 cycles.
  - Equal (k=WIDTH): SHIFT occupies T+1..T+WIDTH. done and equal=1 in cycle T+WIDTH+1.
- busy falls in the same cycle done rises. done is high for exactly one cycle per accepted start.
- Result flags persist after done through IDLE. They clear at the next accepted start edge.
- WIDTH=1: the single SHIFT cycle always terminates. done occurs at T+2.

## Test plan
- WIDTH=8, a_in=0xA5, b_in=0xA5, start at T -> busy high T+1..T+8; done and equal=1 at T+9; greater=lesser=0.
- WIDTH=8, a_in=0x80, b_in=0x7F -> MSB differs; done and greater=1 at T+2; busy high only in T+1.
- WIDTH=8, a_in=0x12, b_in=0x13 -> first difference at bit 0; done and lesser=1 at T+9; flags hold through 5 idle cycles.
- WIDTH=8, 0x40 vs 0x00, start re-asserted with 0xFF/0x01 during SHIFT, then again in the DONE cycle with 0x01/0x02:
  - Mid-SHIFT start is ignored; the first result is greater at T+3.
  - The start in the DONE cycle is accepted; that cycle's flags clear next edge.
  - lesser=1 (0x01 vs 0x02 differ first at bit 1) follows 8 cycles after the DONE cycle.
- WIDTH=8, start a compare and assert rst for one cycle at T+3 -> all outputs 0 from T+4; no done pulse ever appears for the aborted compare; a fresh start at T+6 behaves normally.
- WIDTH=1 build, all four (a,b) pairs -> done at T+2 with lesser only for (0,1), greater only for (1,0), equal for (0,0) and (1,1).
